// File: rtl/press_classifier_pkg.sv
// Shared types and default thresholds for the press_classifier block.
package press_classifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_LONG   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } state_e;

  localparam int unsigned DEF_CNT_W        = 12;
  localparam int unsigned DEF_LONG_TICKS   = 1000;
  localparam int unsigned DEF_DOUBLE_TICKS = 250;
  localparam int unsigned DEF_REPEAT_TICKS = 100;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/press_classifier_tick_counter.sv
// Saturating tick counter with synchronous clear; clear wins over enable.
module tick_counter
  import press_classifier_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {W{1'b0}};
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short/double/long/repeat event pulses.
// Optional auto-repeat in the LONG state is enabled by defining AUTOREPEAT_EN.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned DOUBLE_TICKS = DEF_DOUBLE_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

  if ((max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS) > ((64'd1 << CNT_W) - 64'd1)) ||
      (LONG_TICKS < 1) || (DOUBLE_TICKS < 1) || (REPEAT_TICKS < 1)) begin : g_bad_params
    $error("press_classifier: thresholds must be >= 1 and fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             rep_hit;
  logic             cnt_clear;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;

  assign level_d = level;
  assign rise    = level & ~level_q;
  assign fall    = ~level & level_q;

  tick_counter #(.W(CNT_W)) u_tick_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (tick),
    .cnt   (cnt)
  );

  // Edges are tested before terminal ticks so a coincident edge always wins.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
        else      state_d = ST_IDLE;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_GAP;
        end else if (tick && (cnt == LONG_LAST)) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end else begin
          state_d = ST_PRESS1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LONG;
`ifdef AUTOREPEAT_EN
          if (tick && (cnt == CNT_W'(REPEAT_TICKS - 1))) rep_hit = 1'b1;
          else                                           rep_hit = 1'b0;
`endif
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (tick && (cnt == DOUBLE_LAST)) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else begin
          state_d = ST_PRESS2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d    = (state_d != ST_IDLE);
    cnt_clear = (state_d != state_q) | rep_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

`ifdef AUTOREPEAT_EN
  logic repeat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= rep_hit;
    end
  end

  assign repeat_press = repeat_q;
`else
  assign repeat_press = 1'b0;
`endif

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign busy         = busy_q;

endmodule

// File: doc/press_classifier.md
# press_classifier

Classifies debounced button activity into discrete events. Sits directly downstream of the input debounce filter: it consumes the filter's debounced level and the same millisecond clock-enable tick, and emits one-cycle event pulses (short press, double press, long press, optional auto-repeat) to the control logic.

## Interface
Parameters:
- CNT_W, 12: width of the tick counter; must hold max(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS).
- LONG_TICKS, 1000: ticks held before a press counts as long.
- DOUBLE_TICKS, 250: ticks after a release during which a second press counts as double.
- REPEAT_TICKS, 100: auto-repeat period in ticks while a long press is held.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  clock enable, one-cycle pulse; same signal as the filter's clock_enable.
- level  in  1  debounced button level from the filter (1 = pressed).
- short_press  out  1  one-cycle pulse: single short press completed.
- double_press  out  1  one-cycle pulse: second press released inside the double window.
- long_press  out  1  one-cycle pulse: hold reached LONG_TICKS.
- repeat_press  out  1  one-cycle pulse every REPEAT_TICKS while long-held (AUTOREPEAT_EN only).
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Internal level_q register (reset 0); rise = level & ~level_q, fall = ~level & level_q.
- Counter cnt (CNT_W bits), cleared on every state transition, increments only when tick=1, saturates at all-ones.
- States and transitions:
  - IDLE: rise -> PRESS1.
  - PRESS1: fall -> GAP; tick with cnt == LONG_TICKS-1 -> LONG (long_press).
  - LONG: fall -> IDLE, no further pulse. With AUTOREPEAT_EN: tick with cnt == REPEAT_TICKS-1 -> repeat_press, cnt cleared, stay in LONG.
  - GAP: rise -> PRESS2; tick with cnt == DOUBLE_TICKS-1 -> IDLE (short_press).
  - PRESS2: fall -> IDLE (double_press), regardless of hold duration; counter unused.
- Edge has priority over tick in the same cycle (e.g. PRESS1 with fall and terminal tick together -> GAP, no long_press).
- At most one event pulse is asserted in any cycle.
- busy = (state != IDLE), registered with the state.

## Timing
- Reset: state IDLE, cnt 0, level_q 0, all outputs 0; asynchronous assert, synchronous release.
- Reset mid-operation discards the pending event; no pulse on reset release. If level is 1 at release, a rise is seen on the first clock (level_q starts at 0).
- Event pulses are registered: asserted on the clock edge following the cycle in which the triggering edge or tick is sampled, high for exactly one clk cycle.
- Long press: long_press rises LONG_TICKS ticks after the cycle the rise was sampled.
- Short press: short_press rises DOUBLE_TICKS ticks after release; the latency is intentional, to disambiguate it from a double press.
- tick held high continuously is legal (counts every clk).

## Configuration
- AUTOREPEAT_EN defined: LONG state generates repeat_press every REPEAT_TICKS ticks until release.
- Not defined: repeat_press tied to 0, repeat logic and the REPEAT_TICKS compare are absent; LONG waits only for release.

## Structure
- press_classifier_pkg: state enum (IDLE, PRESS1, LONG, GAP, PRESS2) and default threshold constants.
- One sub-module: tick_counter (clear, enable, saturating count output), instanced once for cnt.
- Edge detection, FSM and output registers live in the top module.

## Test plan
Bench values: LONG_TICKS=8, DOUBLE_TICKS=4, REPEAT_TICKS=2, tick=1 every cycle.
- level high 3 cycles then low, no further activity -> exactly one short_press, 4 cycles after release; no other pulses.
- level high 3, low 2, high 2, low -> one double_press, one cycle after the second fall; no short_press.
- level high 20 cycles -> long_press 8 cycles after the rise; nothing further without AUTOREPEAT_EN; with it, repeat_press every 2 cycles until release.
- Fall coincident with the 8th tick in PRESS1 -> no long_press; FSM in GAP; short_press follows 4 ticks later.
- rst_n pulsed low during GAP -> all outputs 0 immediately, busy 0, no short_press afterwards.
- tick held low while level toggles once -> FSM reaches GAP and stays there, busy=1, no events until tick resumes.
